// File: rtl/max_finder_if.sv
// Bundle between the max-search controller and its datapath: control strobes,
// read address, array load port, and the status/result signals coming back.
interface max_finder_if #(parameter int DATA_W = 8);
  logic              select1;
  logic              select2;
  logic              set_i;
  logic              i_incr;
  logic              set_max;
  logic              set_max_i;
  logic              clr_max_i;
  logic              A_R0;
  logic              A_R1;
  logic              A_R2;
  logic              completed;
  logic              wr_en;
  logic [2:0]        wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [3:0]        i;
  logic              i_smaller;
  logic              A_i_bigger;
  logic [DATA_W-1:0] max_val;
  logic [3:0]        max_idx;
  logic [DATA_W-1:0] res_val;
  logic [3:0]        res_idx;
  logic              res_valid;

  modport master (
    output select1, select2, set_i, i_incr, set_max, set_max_i, clr_max_i,
    output A_R0, A_R1, A_R2, completed, wr_en, wr_addr, wr_data,
    input  i, i_smaller, A_i_bigger, max_val, max_idx, res_val, res_idx, res_valid
  );

  modport slave (
    input  select1, select2, set_i, i_incr, set_max, set_max_i, clr_max_i,
    input  A_R0, A_R1, A_R2, completed, wr_en, wr_addr, wr_data,
    output i, i_smaller, A_i_bigger, max_val, max_idx, res_val, res_idx, res_valid
  );
endinterface

// File: rtl/max_finder_datapath.sv
// Datapath of a max-search engine: 8-entry element array, index register,
// running maximum with its index, and a result latch set by the controller.
module max_finder_datapath #(
  parameter int DATA_W = 8
) (
  input logic          clk,
  input logic          rst_n,
  max_finder_if.slave  bus
);

  logic [DATA_W-1:0] mem [8];
  logic [2:0]        addr;
  logic [DATA_W-1:0] rd_data;
  logic [3:0]        idx;
  logic [DATA_W-1:0] max_q;
  logic [3:0]        max_idx_q;
  logic [DATA_W-1:0] res_val_q;
  logic [3:0]        res_idx_q;
  logic              res_valid_q;

  assign addr    = {bus.A_R2, bus.A_R1, bus.A_R0};
  assign rd_data = mem[addr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 8; k++) mem[k] <= '0;
    end else if (bus.wr_en) begin
      mem[bus.wr_addr] <= bus.wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx <= '0;
    end else if (bus.set_i) begin
      idx <= '0;
    end else if (bus.i_incr) begin
      idx <= idx + 4'd1;
    end
  end

  // select2 seeds the maximum from A[0]; select1 takes the addressed element.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      max_q <= '0;
    end else if (bus.set_max && bus.select2) begin
      max_q <= mem[0];
    end else if (bus.set_max && bus.select1) begin
      max_q <= rd_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      max_idx_q <= '0;
    end else if (bus.clr_max_i) begin
      max_idx_q <= '0;
    end else if (bus.set_max_i) begin
      max_idx_q <= idx;
    end
  end

  // A completion pulse wins over a concurrent write when deciding res_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_val_q   <= '0;
      res_idx_q   <= '0;
      res_valid_q <= 1'b0;
    end else if (bus.completed) begin
      res_val_q   <= max_q;
      res_idx_q   <= max_idx_q;
      res_valid_q <= 1'b1;
    end else if (bus.wr_en) begin
      res_valid_q <= 1'b0;
    end
  end

  assign bus.i          = idx;
  assign bus.i_smaller  = (idx < 4'd7);
  assign bus.A_i_bigger = (rd_data > max_q);
  assign bus.max_val    = max_q;
  assign bus.max_idx    = max_idx_q;
  assign bus.res_val    = res_val_q;
  assign bus.res_idx    = res_idx_q;
  assign bus.res_valid  = res_valid_q;

endmodule
